// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: flag register, conditional BR, CALL/RET return stack, IRQ entry/RETI.
// Latency: every redirect is registered and appears one cycle after the causing edge.
// No backpressure: one instruction per cycle, accepted unconditionally; upstream re-issues anything preempted by irq_take.
module branch_resolve_unit #(
    parameter int ADDR_W      = 32,
    parameter int STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [4:0]        opcode,
    input  logic [1:0]        cond,
    input  logic [1:0]        alu_flags,
    input  logic [ADDR_W-1:0] pc_plus1,
    input  logic [ADDR_W-1:0] target,
    input  logic              irq_take,
    input  logic [ADDR_W-1:0] irq_ret_addr,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [1:0]        flags_q,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              in_isr,
    output logic              stack_err
);
    localparam int SP_W = $clog2(STACK_DEPTH);

    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SUBI = 5'b00101;
    localparam logic [4:0] OP_MUL  = 5'b00110;
    localparam logic [4:0] OP_DIV  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_ANDI = 5'b01011;
    localparam logic [4:0] OP_OR   = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_NOT  = 5'b01110;
    localparam logic [4:0] OP_XOR  = 5'b10000;
    localparam logic [4:0] OP_XORI = 5'b10001;
    localparam logic [4:0] OP_CMP  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10100;
    localparam logic [4:0] OP_CALL = 5'b11001;
    localparam logic [4:0] OP_RET  = 5'b11010;
    localparam logic [4:0] OP_RETI = 5'b11011;

    localparam logic [SP_W:0]   SP_ONE  = 1;
    localparam logic [SP_W:0]   SP_MAX  = STACK_DEPTH[SP_W:0];
    localparam logic [SP_W-1:0] IDX_ONE = 1;

    logic              r_redirect;
    logic [ADDR_W-1:0] r_redirect_pc;
    logic [1:0]        r_flags;
    logic [1:0]        r_shadow;
    logic [ADDR_W-1:0] r_saved_ra;
    logic [SP_W:0]     r_sp;
    logic              r_in_isr;
    logic              r_err;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

    logic              w_flag_wr;
    logic              w_cond_true;
    logic              w_empty;
    logic              w_full;
    logic              w_irq_acc;
    logic              w_exec;
    logic              w_push;
    logic [SP_W-1:0]   w_push_idx;
    logic [SP_W-1:0]   w_top_idx;

    // Decode flag writers and evaluate the branch condition against the pre-update flags.
    always_comb begin
        w_flag_wr = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_DIV, OP_AND, OP_ANDI,
            OP_OR, OP_ORI, OP_NOT, OP_XOR, OP_XORI, OP_CMP: w_flag_wr = 1'b1;
            default: w_flag_wr = 1'b0;
        endcase
        w_cond_true = 1'b0;
        case (cond)
            2'b00:   w_cond_true = r_flags[1];
            2'b01:   w_cond_true = r_flags[0];
            2'b10:   w_cond_true = ~r_flags[1] & ~r_flags[0];
            default: w_cond_true = ~r_flags[1];
        endcase
        w_empty    = (r_sp == '0);
        w_full     = (r_sp == SP_MAX);
        // An accepted interrupt swallows the instruction presented in the same cycle.
        w_irq_acc  = irq_take & ~r_in_isr;
        w_exec     = valid_in & ~w_irq_acc;
        w_push     = w_exec & (opcode == OP_CALL) & ~w_full;
        // sp==STACK_DEPTH wraps the low bits to 0, so top = low bits - 1 stays correct.
        w_push_idx = r_sp[SP_W-1:0];
        w_top_idx  = r_sp[SP_W-1:0] - IDX_ONE;
    end

    // Return-address storage; only entries below sp are ever read, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= pc_plus1;
        end
    end

    // Architectural state and the registered redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_flags       <= 2'b00;
            r_shadow      <= 2'b00;
            r_saved_ra    <= '0;
            r_sp          <= '0;
            r_in_isr      <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_redirect <= 1'b0;
            if (w_irq_acc) begin
                r_shadow      <= r_flags;
                r_saved_ra    <= irq_ret_addr;
                r_in_isr      <= 1'b1;
                r_redirect    <= 1'b1;
                r_redirect_pc <= '0;
            end else if (w_exec) begin
                if (w_flag_wr) begin
                    r_flags <= alu_flags;
                end
                case (opcode)
                    OP_BR: begin
                        if (w_cond_true) begin
                            r_redirect    <= 1'b1;
                            r_redirect_pc <= target;
                        end
                    end
                    OP_CALL: begin
                        if (!w_full) begin
                            r_sp          <= r_sp + SP_ONE;
                            r_redirect    <= 1'b1;
                            r_redirect_pc <= target;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    OP_RET: begin
                        if (!w_empty) begin
                            r_sp          <= r_sp - SP_ONE;
                            r_redirect    <= 1'b1;
                            r_redirect_pc <= r_stack[w_top_idx];
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    OP_RETI: begin
                        if (r_in_isr) begin
                            r_flags       <= r_shadow;
                            r_in_isr      <= 1'b0;
                            r_redirect    <= 1'b1;
                            r_redirect_pc <= r_saved_ra;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign flags_q     = r_flags;
    assign stack_empty = w_empty;
    assign stack_full  = w_full;
    assign in_isr      = r_in_isr;
    assign stack_err   = r_err;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit.
// Each driven cycle pushes its expected redirect; a monitor pops and compares 2 time units after the edge.
// Status outputs are compared inline by each scenario task.
module tb_branch_resolve_unit;
    localparam int AW = 32;
    localparam int DEPTH = 8;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_CMP  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10100;
    localparam logic [4:0] OP_CALL = 5'b11001;
    localparam logic [4:0] OP_RET  = 5'b11010;
    localparam logic [4:0] OP_RETI = 5'b11011;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [4:0]    opcode;
    logic [1:0]    cond;
    logic [1:0]    alu_flags;
    logic [AW-1:0] pc_plus1;
    logic [AW-1:0] target;
    logic          irq_take;
    logic [AW-1:0] irq_ret_addr;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [1:0]    flags_q;
    logic          stack_empty;
    logic          stack_full;
    logic          in_isr;
    logic          stack_err;

    typedef struct {
        logic          redir;
        logic [AW-1:0] pc;
    } exp_t;

    exp_t          sb_q[$];
    logic [AW-1:0] ras_model[$];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode), .cond(cond),
        .alu_flags(alu_flags), .pc_plus1(pc_plus1), .target(target),
        .irq_take(irq_take), .irq_ret_addr(irq_ret_addr),
        .redirect(redirect), .redirect_pc(redirect_pc), .flags_q(flags_q),
        .stack_empty(stack_empty), .stack_full(stack_full), .in_isr(in_isr),
        .stack_err(stack_err)
    );

    // Scoreboard monitor: one expected entry per driven cycle.
    always begin
        exp_t e;
        @(posedge clk);
        #2;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (redirect !== e.redir || (e.redir && redirect_pc !== e.pc)) begin
                errors++;
                $display("FAIL redirect_sb: got redirect=%b pc=%h, expected redirect=%b pc=%h",
                         redirect, redirect_pc, e.redir, e.pc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs and record the redirect expected after the next edge.
    task automatic drive(input logic v, input logic [4:0] op, input logic [1:0] c,
                         input logic [1:0] f, input logic [AW-1:0] p1, input logic [AW-1:0] tg,
                         input logic irq, input logic [AW-1:0] ira,
                         input logic er, input logic [AW-1:0] epc);
        exp_t e;
        valid_in = v; opcode = op; cond = c; alu_flags = f;
        pc_plus1 = p1; target = tg; irq_take = irq; irq_ret_addr = ira;
        e.redir = er; e.pc = epc;
        sb_q.push_back(e);
        @(posedge clk);
        #3;
    endtask

    task automatic idle(input logic [1:0] f);
        drive(1'b0, OP_ADD, 2'b00, f, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic apply_reset();
        valid_in = 1'b0; irq_take = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        ras_model.delete();
    endtask

    task automatic test_reset();
        valid_in = 1'b0; opcode = OP_NOP; cond = 2'b00; alu_flags = 2'b00;
        pc_plus1 = '0; target = '0; irq_take = 1'b0; irq_ret_addr = '0;
        rst = 1'b1;
        #1;
        checks++;
        if ({redirect, redirect_pc, flags_q, stack_empty, stack_full, in_isr, stack_err} !==
            {1'b0, {AW{1'b0}}, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got redir=%b pc=%h flags=%b empty=%b full=%b isr=%b err=%b",
                     redirect, redirect_pc, flags_q, stack_empty, stack_full, in_isr, stack_err);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic test_branch();
        drive(1'b1, OP_CMP, 2'b00, 2'b10, '0, '0, 1'b0, '0, 1'b0, '0);
        checks++;
        if (flags_q !== 2'b10) begin
            errors++; $display("FAIL cmp_flags: got %b, expected 10", flags_q);
        end
        drive(1'b1, OP_BR, 2'b00, 2'b01, '0, 32'h40, 1'b0, '0, 1'b1, 32'h40);
        idle(2'b11);
        drive(1'b1, OP_BR, 2'b11, 2'b00, '0, 32'h44, 1'b0, '0, 1'b0, '0);
        checks++;
        if (flags_q !== 2'b10) begin
            errors++; $display("FAIL flags_hold: got %b, expected 10", flags_q);
        end
        drive(1'b1, OP_ADD, 2'b00, 2'b00, '0, '0, 1'b0, '0, 1'b0, '0);
        drive(1'b1, OP_BR, 2'b10, 2'b00, '0, 32'h48, 1'b0, '0, 1'b1, 32'h48);
        drive(1'b1, OP_BR, 2'b01, 2'b00, '0, 32'h4C, 1'b0, '0, 1'b0, '0);
        drive(1'b1, OP_ADD, 2'b00, 2'b01, '0, '0, 1'b0, '0, 1'b0, '0);
        drive(1'b1, OP_BR, 2'b01, 2'b00, '0, 32'h50, 1'b0, '0, 1'b1, 32'h50);
        drive(1'b1, OP_BR, 2'b10, 2'b00, '0, 32'h54, 1'b0, '0, 1'b0, '0);
        drive(1'b1, OP_BR, 2'b11, 2'b00, '0, 32'h58, 1'b0, '0, 1'b1, 32'h58);
        drive(1'b1, OP_NOP, 2'b00, 2'b10, '0, '0, 1'b0, '0, 1'b0, '0);
        idle(2'b10);
        checks++;
        if (flags_q !== 2'b01) begin
            errors++; $display("FAIL no_effect_flags: got %b, expected 01", flags_q);
        end
    endtask

    task automatic test_call_ret();
        drive(1'b1, OP_CALL, 2'b00, 2'b00, 32'h11, 32'h80, 1'b0, '0, 1'b1, 32'h80);
        checks++;
        if (stack_empty !== 1'b0) begin
            errors++; $display("FAIL call_nonempty: got empty=%b, expected 0", stack_empty);
        end
        drive(1'b1, OP_RET, 2'b00, 2'b00, '0, '0, 1'b0, '0, 1'b1, 32'h11);
        checks++;
        if (stack_empty !== 1'b1 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL ret_empty_again: got empty=%b err=%b, expected 1 0", stack_empty, stack_err);
        end
    endtask

    task automatic test_ret_empty();
        drive(1'b1, OP_RET, 2'b00, 2'b00, '0, '0, 1'b0, '0, 1'b0, '0);
        checks++;
        if (stack_err !== 1'b1) begin
            errors++; $display("FAIL ret_underflow_err: got %b, expected 1", stack_err);
        end
        drive(1'b1, OP_CALL, 2'b00, 2'b00, 32'h21, 32'h90, 1'b0, '0, 1'b1, 32'h90);
        drive(1'b1, OP_RET, 2'b00, 2'b00, '0, '0, 1'b0, '0, 1'b1, 32'h21);
        repeat (3) idle(2'b00);
        checks++;
        if (stack_err !== 1'b1 || stack_empty !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got err=%b empty=%b, expected 1 1", stack_err, stack_empty);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, OP_ADD, 2'b00, 2'b11, '0, '0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, OP_CALL, 2'b00, 2'b00, 32'h30 + i, 32'hA0 + i, 1'b0, '0, 1'b1, 32'hA0 + i);
        end
        valid_in = 1'b0;
        checks++;
        if (redirect !== 1'b1 || flags_q !== 2'b11 || stack_empty !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset: got redir=%b flags=%b empty=%b, expected 1 11 0",
                     redirect, flags_q, stack_empty);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (redirect !== 1'b0 || flags_q !== 2'b00 || stack_empty !== 1'b1 ||
            in_isr !== 1'b0 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got redir=%b flags=%b empty=%b isr=%b err=%b",
                     redirect, flags_q, stack_empty, in_isr, stack_err);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic test_stack_full();
        for (int i = 0; i < DEPTH; i++) begin
            ras_model.push_back(32'h100 + i);
            drive(1'b1, OP_CALL, 2'b00, 2'b00, 32'h100 + i, 32'h300 + i, 1'b0, '0, 1'b1, 32'h300 + i);
        end
        checks++;
        if (stack_full !== 1'b1 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL full_after_8: got full=%b err=%b, expected 1 0", stack_full, stack_err);
        end
        drive(1'b1, OP_CALL, 2'b00, 2'b00, 32'h1FF, 32'h3FF, 1'b0, '0, 1'b0, '0);
        checks++;
        if (stack_err !== 1'b1 || stack_full !== 1'b1) begin
            errors++;
            $display("FAIL overflow: got err=%b full=%b, expected 1 1", stack_err, stack_full);
        end
        while (ras_model.size() > 0) begin
            logic [AW-1:0] a;
            a = ras_model.pop_back();
            drive(1'b1, OP_RET, 2'b00, 2'b00, '0, '0, 1'b0, '0, 1'b1, a);
            if (ras_model.size() == DEPTH - 1) begin
                checks++;
                if (stack_full !== 1'b0) begin
                    errors++; $display("FAIL unfull: got full=%b, expected 0", stack_full);
                end
            end
        end
        checks++;
        if (stack_empty !== 1'b1) begin
            errors++; $display("FAIL drained: got empty=%b, expected 1", stack_empty);
        end
    endtask

    task automatic test_irq();
        drive(1'b1, OP_ADD, 2'b00, 2'b01, '0, '0, 1'b0, '0, 1'b0, '0);
        drive(1'b1, OP_CALL, 2'b00, 2'b00, 32'h77, 32'h99, 1'b1, 32'h200, 1'b1, 32'h0);
        checks++;
        if (in_isr !== 1'b1 || stack_empty !== 1'b1 || flags_q !== 2'b01) begin
            errors++;
            $display("FAIL irq_entry: got isr=%b empty=%b flags=%b, expected 1 1 01",
                     in_isr, stack_empty, flags_q);
        end
        drive(1'b1, OP_SUB, 2'b00, 2'b10, '0, '0, 1'b0, '0, 1'b0, '0);
        drive(1'b0, OP_NOP, 2'b00, 2'b00, '0, '0, 1'b1, 32'h300, 1'b0, '0);
        checks++;
        if (flags_q !== 2'b10 || in_isr !== 1'b1) begin
            errors++;
            $display("FAIL isr_body: got flags=%b isr=%b, expected 10 1", flags_q, in_isr);
        end
        drive(1'b1, OP_RETI, 2'b00, 2'b00, '0, '0, 1'b0, '0, 1'b1, 32'h200);
        checks++;
        if (flags_q !== 2'b01 || in_isr !== 1'b0 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL reti: got flags=%b isr=%b err=%b, expected 01 0 0",
                     flags_q, in_isr, stack_err);
        end
        drive(1'b1, OP_RETI, 2'b00, 2'b00, '0, '0, 1'b0, '0, 1'b0, '0);
        checks++;
        if (stack_err !== 1'b1) begin
            errors++; $display("FAIL reti_outside_isr: got err=%b, expected 1", stack_err);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_call_ret();
        test_ret_empty();
        test_reset_mid();
        test_stack_full();
        apply_reset();
        test_irq();
        idle(2'b00);
        @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
